fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch: producer side of the fetch->decode handshake (valid/pc/instruction vs decode stall).
//  Holds the PC and issues one instruction-memory request at a time (variable latency).
//  Presents each fetched instruction to decode_stage until accepted.
//  Redirects on taken branch or jump and squashes wrong-path fetches.
// PARAMETERS
//  DATA_WIDTH  params_pkg::DATA_WIDTH (32)  instruction/data width
//  ADDR_WIDTH  params_pkg::ADDR_WIDTH (32)  PC/address width
//  BOOT_ADDR   params_pkg::BOOT_ADDR        PC after reset (word aligned)
// PORTS
//  clk_i           in   1           clock
//  rst_i           in   1           synchronous reset, active low
//  stall_i         in   1           decode stall; 0 = decode accepts valid_o this cycle
//  branch_taken_i  in   1           redirect request (taken branch)
//  is_jump_i       in   1           redirect request (jump)
//  target_pc_i     in   ADDR_WIDTH  redirect target; bits [1:0] ignored (forced 0)
//  imem_ready_i    in   1           memory accepts imem_req_o this cycle
//  imem_rvalid_i   in   1           response valid
//  imem_rdata_i    in   DATA_WIDTH  response instruction word
//  imem_req_o      out  1           request valid (held until imem_ready_i)
//  imem_addr_o     out  ADDR_WIDTH  request address (= pc_q)
//  valid_o         out  1           instruction_o/pc_o valid for decode
//  pc_o            out  ADDR_WIDTH  PC of instruction_o
//  instruction_o   out  instruction_t  fetched instruction
// BEHAVIOUR
//  - redirect = branch_taken_i | is_jump_i. Redirect beats every other event in the same cycle.
//  - Reset values: state=F_REQ, pc_q=BOOT_ADDR, kill_q=0, valid_o=0, pc_o=BOOT_ADDR,
//    instruction_o=NOP_INSTR (32'h0000_0013).
//    imem_req_o=1 with addr BOOT_ADDR in the first cycle after release.
//  - FSM (imem_req_o = state==F_REQ; valid_o = state==F_HOLD):
//    F_REQ: redirect -> pc_q<=target; stay F_REQ if !imem_ready_i,
//           else F_WAIT with kill_q<=1 (old address accepted).
//           No redirect, imem_ready_i -> F_WAIT.
//    F_WAIT: imem_rvalid_i & (kill_q|redirect) -> discard; kill_q<=0; pc_q<=target if redirect; -> F_REQ.
//            imem_rvalid_i otherwise -> instruction_o<=rdata, pc_o<=pc_q, pc_q<=pc_q+4; -> F_HOLD.
//            redirect without rvalid -> pc_q<=target, kill_q<=1, stay F_WAIT.
//    F_HOLD: redirect -> drop instruction (valid_o=0 next), pc_q<=target -> F_REQ.
//            !stall_i -> accepted -> F_REQ. stall_i -> hold pc_o/instruction_o stable.
//  - Latency: rvalid in cycle N gives valid_o=1 in N+1. One outstanding request max. No bubble-free streaming.
//  - pc_q+4 wraps modulo 2^ADDR_WIDTH.
//  - imem_rvalid_i outside F_WAIT is ignored (simulation assertion fires).
//  - Reset mid-operation: returns to reset values next cycle regardless of state.
//    Imem shares rst_i, so no stale response survives.
//  - imem_addr_o, imem_req_o stable while imem_req_o=1 & !imem_ready_i, except on redirect.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds 32-bit saturating outputs, reset to 0:
//    perf_fetched_o  (+1 per accepted handoff)
//    perf_squashed_o (+1 per discarded response or dropped F_HOLD instruction)
//    perf_stall_o    (+1 per F_HOLD cycle with stall_i=1)
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  params_pkg gains:
//    fetch_state_t enum {F_REQ, F_WAIT, F_HOLD}
//    NOP_INSTR constant
//    BOOT_ADDR constant
//  instruction_t is reused from params_pkg.
//  Optional sub-module fetch_perf_counters (counters only, instantiated under FETCH_PERF_CNT_EN).
//  FSM and PC logic live in fetch_stage.
// TESTING
//  1 Reset release, imem_ready_i=1, 2-cycle latency, rdata=32'h00500093
//    -> valid_o with pc_o=BOOT_ADDR, next request at BOOT_ADDR+4.
//  2 stall_i=1 for 5 cycles in F_HOLD
//    -> pc_o/instruction_o constant, imem_req_o=0; accepted on first stall_i=0.
//  3 branch_taken_i with target 32'h200 in F_WAIT, then response arrives
//    -> response discarded, next request addr 32'h200, no valid_o for old word.
//  4 is_jump_i with target 32'h403 in F_HOLD, stall_i=1
//    -> valid_o=0 next cycle, request addr 32'h400.
//  5 Redirect in the same cycle as imem_ready_i in F_REQ
//    -> kill_q=1, old response dropped, target fetched next.
//  6 pc_q=32'hFFFF_FFFC fetched -> next addr 32'h0.
//    Also: rst_i=0 during F_WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/params_pkg.sv
// Shared core parameters and the fetch-stage types (state encoding, NOP word, boot PC).
package params_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  typedef logic [DATA_WIDTH-1:0] instruction_t;

  localparam logic [ADDR_WIDTH-1:0] BOOT_ADDR = 32'h0000_1000;
  localparam instruction_t          NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    F_REQ,
    F_WAIT,
    F_HOLD
  } fetch_state_t;
endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating event counters for the fetch stage (fetched, squashed, stall cycles).
module fetch_perf_counters (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_fetched_i,
  input  logic        inc_squashed_i,
  input  logic        inc_stall_i,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_squashed_o,
  output logic [31:0] perf_stall_o
);
  logic [2:0][31:0] cnt_q;
  logic [2:0]       inc;

  assign inc = {inc_stall_i, inc_squashed_i, inc_fetched_i};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (inc[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  assign perf_fetched_o  = cnt_q[0];
  assign perf_squashed_o = cnt_q[1];
  assign perf_stall_o    = cnt_q[2];
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, hands words to decode, squashes on redirect.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/squashed/stall counters.
module fetch_stage
  import params_pkg::*;
#(
  parameter int                    DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int                    ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = params_pkg::BOOT_ADDR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic                  is_jump_i,
  input  logic [ADDR_WIDTH-1:0] target_pc_i,
  input  logic                  imem_ready_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output instruction_t          instruction_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched_o,
  output logic [31:0]           perf_squashed_o,
  output logic [31:0]           perf_stall_o
`endif
);
  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
  instruction_t          instr_q, instr_d;
  logic                  kill_q, kill_d;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] target;

  assign redirect = branch_taken_i | is_jump_i;
  assign target   = {target_pc_i[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    case (state_q)
      F_REQ: begin
        if (redirect) begin
          pc_d = target;
          // Memory already took the old address; its response must be dropped.
          if (imem_ready_i) begin
            state_d = F_WAIT;
            kill_d  = 1'b1;
          end
        end else if (imem_ready_i) begin
          state_d = F_WAIT;
        end
      end
      F_WAIT: begin
        if (imem_rvalid_i) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = F_REQ;
            if (redirect) pc_d = target;
          end else begin
            instr_d  = instruction_t'(imem_rdata_i);
            pc_out_d = pc_q;
            pc_d     = pc_q + ADDR_WIDTH'(4);
            state_d  = F_HOLD;
          end
        end else if (redirect) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
      end
      F_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = F_REQ;
        end else if (!stall_i) begin
          state_d = F_REQ;
        end
      end
      default: state_d = F_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= F_REQ;
      pc_q     <= BOOT_ADDR;
      kill_q   <= 1'b0;
      pc_out_q <= BOOT_ADDR;
      instr_q  <= NOP_INSTR;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
    end
  end

  assign imem_req_o    = (state_q == F_REQ);
  assign imem_addr_o   = pc_q;
  assign valid_o       = (state_q == F_HOLD);
  assign pc_o          = pc_out_q;
  assign instruction_o = instr_q;

  a_rvalid_only_in_wait: assert property (@(posedge clk_i) disable iff (!rst_i)
    imem_rvalid_i |-> (state_q == F_WAIT));

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .inc_fetched_i   ((state_q == F_HOLD) && !redirect && !stall_i),
    .inc_squashed_i  (((state_q == F_WAIT) && imem_rvalid_i && (kill_q || redirect)) ||
                      ((state_q == F_HOLD) && redirect)),
    .inc_stall_i     ((state_q == F_HOLD) && stall_i),
    .perf_fetched_o  (perf_fetched_o),
    .perf_squashed_o (perf_squashed_o),
    .perf_stall_o    (perf_stall_o)
  );
`endif
endmodule
